writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
//  Parametrised MEM/WB pipeline stage and register-file write port driver.
//  Holds one retiring instruction and selects its result from ALU, load data,
//  link value or immediate. Load data comes from a 1-cycle synchronous RAM.
//  Stalls on a busy RF port, supports flush, and counts retired instructions.
// PARAMETERS
//  DATA_W      8  datapath / register width
//  REG_ADDR_W  3  register-file address width
//  CNT_W      16  retire counter width
//  ZERO_REG    1  1: writes to register 0 are suppressed (instruction still retires)
// PORTS
//  clk            in   1           rising-edge clock
//  reset_n        in   1           asynchronous, active-low reset
//  flush          in   1           kill held entry, block acceptance this cycle
//  in_valid       in   1           upstream entry valid
//  in_ready       out  1           stage can accept this cycle
//  in_result_src  in   2           0 ALU, 1 MEM, 2 LINK, 3 IMM
//  in_reg_write   in   1           instruction writes RF
//  in_rd          in   REG_ADDR_W  destination register
//  in_alu_result  in   DATA_W      ALU result
//  in_link        in   DATA_W      return address (PC+1)
//  in_imm         in   DATA_W      immediate
//  mem_rdata      in   DATA_W      load data; valid only in the cycle after acceptance
//  rf_ready       in   1           RF write port granted this cycle
//  rf_we          out  1           RF write strobe
//  rf_waddr       out  REG_ADDR_W  RF write address
//  rf_wdata       out  DATA_W      RF write data
//  retire_count   out  CNT_W       retired-instruction count
// BEHAVIOUR
//  - Reset (async, reset_n=0): v_q=0, first_q=0, all data regs=0, retire_count=0.
//    Outputs: rf_we=0, rf_waddr=0, rf_wdata=0, in_ready=1 once reset deasserts.
//  - State is a single entry: EMPTY (v_q=0) and HELD (v_q=1).
//  - commit = v_q & rf_ready & ~flush.
//  - in_ready = ~flush & (~v_q | commit). accept = in_valid & in_ready.
//  - accept: latch src/we/rd/alu/link/imm, set v_q=1, set first_q=1.
//    Simultaneous commit and accept means back-to-back operation (1 instr/cycle).
//  - commit without accept: v_q <= 0. Flush: v_q <= 0 and first_q <= 0. No
//    rf_we and no retire during flush.
//  - Load capture: while first_q=1, the MEM result is mem_rdata (combinational)
//    and is also registered into mem_q. The next cycle clears first_q. Later
//    (stalled) cycles use mem_q. Stalls therefore never lose load data.
//  - rf_wdata = mux(src_q: alu_q, mem_sel, link_q, imm_q); rf_waddr = rd_q.
//    Both are driven while v_q=1 and hold their last value otherwise.
//  - rf_we = commit & we_q & ~(ZERO_REG & rd_q==0).
//  - retire_count increments on every commit (incl. we_q=0 or rd 0).
//    It wraps modulo 2^CNT_W.
//  - Latency: accept at edge N leads to the earliest RF write in cycle N+1.
// CONFIGURATION
//  - Macro WB_FWD_EN defined: add outputs fwd_valid(1), fwd_rd(REG_ADDR_W),
//    fwd_data(DATA_W).
//    fwd_valid = v_q & we_q & ~flush, independent of rf_ready.
//    fwd_data equals rf_wdata.
//  - WB_FWD_EN undefined: these ports and their logic are absent.
//    All other behaviour is identical.
// STRUCTURE
//  - Shared package wb_pkg: result-source encodings SRC_ALU=2'd0, SRC_MEM=2'd1,
//    SRC_LINK=2'd2, SRC_IMM=2'd3. The package is shared with decode and the hazard unit.
//  - Sub-module wb_result_mux: combinational 4:1 DATA_W selector keyed by the
//    wb_pkg encodings.
//  - Top level holds the entry register, the load-capture flag, the handshake
//    and the retire counter.
// TESTING
//  1. ALU path: accept src=0, rd=5, alu=8'h3C, rf_ready=1. Next cycle: rf_we=1,
//     waddr=5, wdata=3C, retire_count=1.
//  2. Load with stall: accept src=1, rd=2. mem_rdata=8'hA5 in cycle N+1 and 8'h00
//     after, rf_ready low 3 cycles. On grant: wdata=A5, in_ready=0 during the stall.
//  3. Back-to-back: 4 valid instrs with rf_ready=1 throughout. One write per cycle,
//     in_ready stays 1, retire_count=4.
//  4. Flush while HELD and stalled, with in_valid=1. No rf_we, in_ready=0 that cycle,
//     retire_count unchanged, then EMPTY.
//  5. ZERO_REG=1, rd=0, we=1: no rf_we, retire_count still increments.
//     Preload count to FFFF, then one commit gives 0000.
//  6. Assert reset_n=0 mid-stall. v_q and rf_we clear immediately (async), counter=0.
//     With WB_FWD_EN, fwd_valid tracks v_q&we_q across a stall.

Source files
------------

// File: rtl/wb_pkg.sv
// Writeback-stage shared definitions: result-source encodings and entry state.
// Shared with decode and the hazard unit.
package wb_pkg;

   localparam logic [1:0] SRC_ALU  = 2'd0;
   localparam logic [1:0] SRC_MEM  = 2'd1;
   localparam logic [1:0] SRC_LINK = 2'd2;
   localparam logic [1:0] SRC_IMM  = 2'd3;

   typedef enum logic {
      WB_EMPTY = 1'b0,
      WB_HELD  = 1'b1
   } wb_state_e;

endpackage

// File: rtl/wb_result_mux.sv
// Combinational 4:1 writeback result selector keyed by the wb_pkg source encodings.
module wb_result_mux
   import wb_pkg::*;
#(
   parameter int DATA_W = 8
)(
   input  logic [1:0]        sel,
   input  logic [DATA_W-1:0] alu,
   input  logic [DATA_W-1:0] mem,
   input  logic [DATA_W-1:0] link,
   input  logic [DATA_W-1:0] imm,
   output logic [DATA_W-1:0] result
);

   always_comb begin
      result = alu;
      case (sel)
         SRC_ALU:  result = alu;
         SRC_MEM:  result = mem;
         SRC_LINK: result = link;
         SRC_IMM:  result = imm;
         default:  result = alu;
      endcase
   end

endmodule

// File: rtl/writeback_unit.sv
// MEM/WB stage: one-entry holding register driving the RF write port, with retire counter.
// Define WB_FWD_EN to add the fwd_valid / fwd_rd / fwd_data forwarding outputs.
module writeback_unit
   import wb_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int REG_ADDR_W = 3,
   parameter int CNT_W      = 16,
   parameter int ZERO_REG   = 1
)(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            in_result_src,
   input  logic                  in_reg_write,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic [DATA_W-1:0]     in_alu_result,
   input  logic [DATA_W-1:0]     in_link,
   input  logic [DATA_W-1:0]     in_imm,
   input  logic [DATA_W-1:0]     mem_rdata,
   input  logic                  rf_ready,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0]     rf_wdata,
   output logic [CNT_W-1:0]      retire_count,
   output wb_state_e             state_dbg
`ifdef WB_FWD_EN
   ,
   output logic                  fwd_valid,
   output logic [REG_ADDR_W-1:0] fwd_rd,
   output logic [DATA_W-1:0]     fwd_data
`endif
);

   // Handshake: an entry transfers on any cycle where in_valid and in_ready are both
   // high; in_ready never depends on in_valid, and flush blocks transfer that cycle.

   wb_state_e             state_q, state_d;
   logic                  v_q, first_q, we_q;
   logic                  commit, accept, zero_hit;
   logic [1:0]            src_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic [DATA_W-1:0]     alu_q, link_q, imm_q, mem_q, mem_sel, result;
   logic [CNT_W-1:0]      cnt_q;

   assign v_q = (state_q == WB_HELD);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= WB_EMPTY;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         WB_EMPTY: if (accept) state_d = WB_HELD;
         WB_HELD: begin
            if (flush)                  state_d = WB_EMPTY;
            else if (commit && !accept) state_d = WB_EMPTY;
         end
         default: state_d = WB_EMPTY;
      endcase
   end

   always_comb begin
      commit   = v_q & rf_ready & ~flush;
      in_ready = ~flush & (~v_q | commit);
      accept   = in_valid & in_ready;
      rf_we    = commit & we_q & ~zero_hit;
   end

   assign zero_hit = (ZERO_REG != 0) && (rd_q == '0);

   // Load data is only presented in the cycle after acceptance; mem_q keeps it for stalls.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         first_q <= 1'b0;
         src_q   <= SRC_ALU;
         we_q    <= 1'b0;
         rd_q    <= '0;
         alu_q   <= '0;
         link_q  <= '0;
         imm_q   <= '0;
         mem_q   <= '0;
         cnt_q   <= '0;
      end else begin
         first_q <= accept;
         if (first_q) mem_q <= mem_rdata;
         if (accept) begin
            src_q  <= in_result_src;
            we_q   <= in_reg_write;
            rd_q   <= in_rd;
            alu_q  <= in_alu_result;
            link_q <= in_link;
            imm_q  <= in_imm;
         end
         if (commit) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign mem_sel = first_q ? mem_rdata : mem_q;

   wb_result_mux #(.DATA_W(DATA_W)) u_result_mux (
      .sel    (src_q),
      .alu    (alu_q),
      .mem    (mem_sel),
      .link   (link_q),
      .imm    (imm_q),
      .result (result)
   );

   // Entry registers only change on accept, so an empty stage keeps showing the last entry.
   assign rf_waddr     = rd_q;
   assign rf_wdata     = result;
   assign retire_count = cnt_q;
   assign state_dbg    = state_q;

`ifdef WB_FWD_EN
   assign fwd_valid = v_q & we_q & ~flush;
   assign fwd_rd    = rd_q;
   assign fwd_data  = result;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed vectors plus a per-cycle reference model.
// Forwarding outputs are checked when WB_FWD_EN is defined.
module tb_writeback_unit;
   import wb_pkg::*;

   localparam int DATA_W     = 8;
   localparam int REG_ADDR_W = 3;
   localparam int CNT_W      = 16;

   logic                  clk = 1'b0;
   logic                  reset_n = 1'b0;
   logic                  flush = 1'b0;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic [1:0]            in_result_src = 2'd0;
   logic                  in_reg_write = 1'b0;
   logic [REG_ADDR_W-1:0] in_rd = '0;
   logic [DATA_W-1:0]     in_alu_result = '0;
   logic [DATA_W-1:0]     in_link = '0;
   logic [DATA_W-1:0]     in_imm = '0;
   logic [DATA_W-1:0]     mem_rdata = '0;
   logic                  rf_ready = 1'b0;
   logic                  rf_we;
   logic [REG_ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0]     rf_wdata;
   logic [CNT_W-1:0]      retire_count;
   wb_state_e             state_dbg;
`ifdef WB_FWD_EN
   logic                  fwd_valid;
   logic [REG_ADDR_W-1:0] fwd_rd;
   logic [DATA_W-1:0]     fwd_data;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [REG_ADDR_W+DATA_W-1:0] exp_q[$];

   writeback_unit #(
      .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W), .ZERO_REG(1)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_result_src (in_result_src),
      .in_reg_write  (in_reg_write),
      .in_rd         (in_rd),
      .in_alu_result (in_alu_result),
      .in_link       (in_link),
      .in_imm        (in_imm),
      .mem_rdata     (mem_rdata),
      .rf_ready      (rf_ready),
      .rf_we         (rf_we),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata),
      .retire_count  (retire_count),
      .state_dbg     (state_dbg)
`ifdef WB_FWD_EN
      ,
      .fwd_valid     (fwd_valid),
      .fwd_rd        (fwd_rd),
      .fwd_data      (fwd_data)
`endif
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- check helper ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [1:0] src, input logic we, input logic [REG_ADDR_W-1:0] rd,
                            input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] link,
                            input logic [DATA_W-1:0] imm);
      in_valid      = 1'b1;
      in_result_src = src;
      in_reg_write  = we;
      in_rd         = rd;
      in_alu_result = alu;
      in_link       = link;
      in_imm        = imm;
   endtask

   // ---------------- reference model + compare process ----------------
   // The model tracks one pending instruction and its resolved result value.
   logic                  m_v, m_fresh, m_we;
   logic [REG_ADDR_W-1:0] m_rd;
   logic [DATA_W-1:0]     m_data, m_last;
   logic [CNT_W-1:0]      m_cnt;

   always @(negedge clk) begin : compare
      logic              e_ready, e_commit, e_we;
      logic [DATA_W-1:0] e_data;
      if (!reset_n) begin
         m_v = 1'b0; m_fresh = 1'b0; m_we = 1'b0; m_rd = '0;
         m_data = '0; m_last = '0; m_cnt = '0;
         exp_q.delete();
         chk("rst_rf_we", 32'(rf_we), 32'd0);
         chk("rst_count", 32'(retire_count), 32'd0);
         chk("rst_waddr", 32'(rf_waddr), 32'd0);
         chk("rst_wdata", 32'(rf_wdata), 32'd0);
         chk("rst_state", 32'(state_dbg), 32'(WB_EMPTY));
      end else begin
         if (m_v && m_fresh) begin
            m_data  = mem_rdata;
            m_fresh = 1'b0;
         end
         e_ready  = !flush && (!m_v || rf_ready);
         e_commit = m_v && rf_ready && !flush;
         e_we     = e_commit && m_we && (m_rd != '0);
         e_data   = m_v ? m_data : m_last;

         chk("m_in_ready", 32'(in_ready), 32'(e_ready));
         chk("m_rf_we", 32'(rf_we), 32'(e_we));
         chk("m_waddr", 32'(rf_waddr), 32'(m_rd));
         chk("m_wdata", 32'(rf_wdata), 32'(e_data));
         chk("m_count", 32'(retire_count), 32'(m_cnt));
         chk("m_state", 32'(state_dbg), m_v ? 32'(WB_HELD) : 32'(WB_EMPTY));
`ifdef WB_FWD_EN
         chk("m_fwd_valid", 32'(fwd_valid), 32'(m_v && m_we && !flush));
         chk("m_fwd_rd", 32'(fwd_rd), 32'(m_rd));
         chk("m_fwd_data", 32'(fwd_data), 32'(e_data));
`endif
         if (e_we) exp_q.push_back({m_rd, m_data});
         if (rf_we) begin
            chk("sb_pending", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) chk("sb_write", 32'({rf_waddr, rf_wdata}), 32'(exp_q.pop_front()));
         end

         if (m_v) m_last = m_data;
         if (e_commit) m_cnt = m_cnt + 1'b1;
         if (in_valid && e_ready) begin
            m_v     = 1'b1;
            m_we    = in_reg_write;
            m_rd    = in_rd;
            m_fresh = (in_result_src == SRC_MEM);
            case (in_result_src)
               SRC_ALU:  m_data = in_alu_result;
               SRC_LINK: m_data = in_link;
               SRC_IMM:  m_data = in_imm;
               default:  m_data = '0;
            endcase
         end else if (e_commit || flush) begin
            m_v = 1'b0;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   logic [1:0]            b_src[4] = '{SRC_LINK, SRC_IMM, SRC_MEM, SRC_ALU};
   logic [REG_ADDR_W-1:0] b_rd[4]  = '{3'd1, 3'd3, 3'd4, 3'd6};
   logic [DATA_W-1:0]     b_exp[4] = '{8'h10, 8'h21, 8'h5A, 8'h43};

   initial begin
      #8 reset_n = 1'b1;
      cycle();
      chk("init_in_ready", 32'(in_ready), 32'd1);
      chk("init_rf_we", 32'(rf_we), 32'd0);
      chk("init_wdata", 32'(rf_wdata), 32'd0);
      chk("init_waddr", 32'(rf_waddr), 32'd0);
      chk("init_count", 32'(retire_count), 32'd0);

      // 1. ALU path
      set_instr(SRC_ALU, 1'b1, 3'd5, 8'h3C, 8'h11, 8'h22);
      rf_ready = 1'b1;
      cycle();
      in_valid = 1'b0; #1;
      chk("alu_we", 32'(rf_we), 32'd1);
      chk("alu_waddr", 32'(rf_waddr), 32'd5);
      chk("alu_wdata", 32'(rf_wdata), 32'h3C);
      cycle();
      chk("alu_count", 32'(retire_count), 32'd1);

      // 2. Load with a three-cycle RF stall
      rf_ready = 1'b0;
      set_instr(SRC_MEM, 1'b1, 3'd2, 8'h77, 8'h66, 8'h55);
      cycle();
      in_valid = 1'b0; mem_rdata = 8'hA5; #1;
      chk("ld_stall1_ready", 32'(in_ready), 32'd0);
      chk("ld_stall1_we", 32'(rf_we), 32'd0);
      chk("ld_stall1_wdata", 32'(rf_wdata), 32'hA5);
      cycle();
      mem_rdata = 8'h00; #1;
      chk("ld_stall2_ready", 32'(in_ready), 32'd0);
      chk("ld_stall2_wdata", 32'(rf_wdata), 32'hA5);
      cycle();
      chk("ld_stall3_ready", 32'(in_ready), 32'd0);
      cycle();
      rf_ready = 1'b1; #1;
      chk("ld_grant_we", 32'(rf_we), 32'd1);
      chk("ld_grant_waddr", 32'(rf_waddr), 32'd2);
      chk("ld_grant_wdata", 32'(rf_wdata), 32'hA5);
      cycle();
      chk("ld_count", 32'(retire_count), 32'd2);

      // 3. Back-to-back, one write per cycle
      for (int i = 0; i < 4; i++) begin
         mem_rdata = (i == 3) ? 8'h5A : 8'h00;
         set_instr(b_src[i], 1'b1, b_rd[i], 8'h40 + 8'(i), 8'h10 + 8'(i), 8'h20 + 8'(i));
         #1;
         chk("b2b_ready", 32'(in_ready), 32'd1);
         if (i > 0) begin
            chk("b2b_we", 32'(rf_we), 32'd1);
            chk("b2b_waddr", 32'(rf_waddr), 32'(b_rd[i-1]));
            chk("b2b_wdata", 32'(rf_wdata), 32'(b_exp[i-1]));
         end
         cycle();
      end
      in_valid = 1'b0; mem_rdata = 8'h00; #1;
      chk("b2b_last_we", 32'(rf_we), 32'd1);
      chk("b2b_last_waddr", 32'(rf_waddr), 32'd6);
      chk("b2b_last_wdata", 32'(rf_wdata), 32'h43);
      cycle();
      chk("b2b_count", 32'(retire_count), 32'd6);

      // 4. Flush while held and stalled, with a new instruction offered
      rf_ready = 1'b0;
      set_instr(SRC_ALU, 1'b1, 3'd7, 8'h77, 8'h00, 8'h00);
      cycle();
      flush = 1'b1;
      set_instr(SRC_IMM, 1'b1, 3'd1, 8'h00, 8'h00, 8'hEE);
      #1;
      chk("flush_ready", 32'(in_ready), 32'd0);
      chk("flush_we", 32'(rf_we), 32'd0);
      cycle();
      flush = 1'b0; in_valid = 1'b0; #1;
      chk("flush_state", 32'(state_dbg), 32'(WB_EMPTY));
      chk("flush_count", 32'(retire_count), 32'd6);
      chk("flush_ready_after", 32'(in_ready), 32'd1);
      rf_ready = 1'b1;
      cycle();
      chk("flush_no_write", 32'(rf_we), 32'd0);
      chk("flush_count2", 32'(retire_count), 32'd6);

      // 5. Register-0 suppression and counter wrap
      set_instr(SRC_ALU, 1'b1, 3'd0, 8'h99, 8'h00, 8'h00);
      cycle();
      in_valid = 1'b0; #1;
      chk("r0_we", 32'(rf_we), 32'd0);
      chk("r0_wdata", 32'(rf_wdata), 32'h99);
      cycle();
      chk("r0_count", 32'(retire_count), 32'd7);
      for (int k = 0; k < 65529; k++) begin
         set_instr(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
         mem_rdata = 8'($urandom_range(0, 255));
         cycle();
      end
      in_valid = 1'b0; #1;
      chk("wrap_ffff", 32'(retire_count), 32'hFFFF);
      cycle();
      chk("wrap_zero", 32'(retire_count), 32'h0000);

      // 6. Asynchronous reset in the middle of a stall
      rf_ready = 1'b0;
      set_instr(SRC_ALU, 1'b1, 3'd3, 8'h31, 8'h00, 8'h00);
      cycle();
      in_valid = 1'b0; #1;
      chk("rst6_held", 32'(state_dbg), 32'(WB_HELD));
`ifdef WB_FWD_EN
      chk("fwd_valid_stall1", 32'(fwd_valid), 32'd1);
      chk("fwd_rd", 32'(fwd_rd), 32'd3);
      chk("fwd_data", 32'(fwd_data), 32'h31);
`endif
      cycle();
`ifdef WB_FWD_EN
      chk("fwd_valid_stall2", 32'(fwd_valid), 32'd1);
`endif
      rf_ready = 1'b1; #1;
      chk("rst6_we_before", 32'(rf_we), 32'd1);
      reset_n = 1'b0; #1;
      chk("rst6_we_async", 32'(rf_we), 32'd0);
      chk("rst6_state_async", 32'(state_dbg), 32'(WB_EMPTY));
      chk("rst6_count_async", 32'(retire_count), 32'd0);
      @(posedge clk); #2;
      rf_ready = 1'b0;
      reset_n = 1'b1; #1;
      chk("rst6_ready_after", 32'(in_ready), 32'd1);
      chk("rst6_count_after", 32'(retire_count), 32'd0);
      cycle();
      cycle();

      // ---------------- report ----------------
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
